// File: rtl/presence_pkg.sv
// rtl/presence_pkg.sv - shared types and default timing for the ultrasonic presence block
//
// Purpose: FSM state encoding, echo width type and the default 50 MHz timing
//          constants used by presence_ultrasonic and the door servo stage.
// Ports:   none (package).

package presence_pkg;

   typedef enum logic [1:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE
   } state_t;

   localparam int WIDTH_W = 21;
   typedef logic [WIDTH_W-1:0] width_t;

   localparam int unsigned CLK_HZ            = 50_000_000;
   localparam int unsigned DEF_TRIG_CYCLES   = 500;        // 10 us
   localparam int unsigned DEF_MEAS_PERIOD   = 3_000_000;  // 60 ms
   localparam int unsigned DEF_ECHO_TIMEOUT  = 1_250_000;  // 25 ms
   localparam int unsigned DEF_NEAR_THRESH   = 58_000;     // about 20 cm
   localparam int unsigned DEF_CONFIRM_COUNT = 3;
   localparam int          CONFIRM_W         = 4;          // holds 1..15

endpackage

// File: rtl/echo_conditioner.sv
// rtl/echo_conditioner.sv - echo synchronizer, optional deglitch filter and edge strobes
//
// Purpose: brings the asynchronous echo into the clk domain and produces
//          registered rise/fall strobes plus a level aligned with them.
//          Macro ECHO_DEGLITCH_EN inserts a 4-sample stability filter.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous reset, active low
//   echo_i   in   raw asynchronous echo
//   rise_o   out  one-cycle strobe, echo rose
//   fall_o   out  one-cycle strobe, echo fell
//   level_o  out  echo level; high from the cycle after rise_o through the fall_o cycle

module echo_conditioner (
   input  logic clk,
   input  logic rst_n,
   input  logic echo_i,
   output logic rise_o,
   output logic fall_o,
   output logic level_o
);

   logic sync1_q, sync2_q;
   logic clean;
   logic prev_q, rise_q, fall_q, level_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= echo_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef ECHO_DEGLITCH_EN
   // Output follows the input only once the current sample and the three
   // before it agree, so both edges are delayed equally by 4 cycles.
   logic [2:0] hist_q;
   logic       filt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_q <= '0;
         filt_q <= 1'b0;
      end else begin
         hist_q <= {hist_q[1:0], sync2_q};
         if (&{hist_q, sync2_q}) begin
            filt_q <= 1'b1;
         end else if (~|{hist_q, sync2_q}) begin
            filt_q <= 1'b0;
         end
      end
   end

   assign clean = filt_q;
`else
   assign clean = sync2_q;
`endif

   // level_q lags prev_q by one so that counting level_o over the span
   // rise_o+1 .. fall_o yields exactly the pulse width.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         level_q <= 1'b0;
      end else begin
         prev_q  <= clean;
         rise_q  <= clean & ~prev_q;
         fall_q  <= ~clean & prev_q;
         level_q <= prev_q;
      end
   end

   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign level_o = level_q;

endmodule

// File: rtl/presence_ultrasonic.sv
// rtl/presence_ultrasonic.sv - HC-SR04 ranger driver with debounced presence flag
//
// Purpose: periodically triggers the sensor, measures the echo width in clk
//          cycles (saturating at ECHO_TIMEOUT) and debounces the near/far
//          classification into presence_detected. Optional macro
//          ECHO_DEGLITCH_EN enables the echo stability filter in echo_conditioner.
// Ports:
//   clk                in   system clock, 50 MHz
//   rst_n              in   synchronous reset, active low
//   echo               in   asynchronous echo from the sensor
//   trig               out  trigger pulse to the sensor
//   presence_detected  out  debounced presence, active high
//   echo_cycles        out  last echo width in clk cycles, saturated at ECHO_TIMEOUT
//   sample_valid       out  one-cycle strobe, echo_cycles updated this cycle

module presence_ultrasonic
   import presence_pkg::*;
#(
   parameter int unsigned TRIG_CYCLES   = DEF_TRIG_CYCLES,
   parameter int unsigned MEAS_PERIOD   = DEF_MEAS_PERIOD,
   parameter int unsigned ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT,
   parameter int unsigned NEAR_THRESH   = DEF_NEAR_THRESH,
   parameter int unsigned CONFIRM_COUNT = DEF_CONFIRM_COUNT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        echo,
   output logic        trig,
   output logic        presence_detected,
   output logic [20:0] echo_cycles,
   output logic        sample_valid
);

   localparam int PER_W = $clog2(MEAS_PERIOD);
   localparam logic [PER_W-1:0] PER_LAST  = PER_W'(MEAS_PERIOD - 1);
   localparam logic [PER_W-1:0] TRIG_LAST = PER_W'(TRIG_CYCLES - 1);
   // The period counter restarts at the trigger, so it doubles as the
   // TRIG and WAIT_RISE timer; MEAS_PERIOD > TRIG + 2*TIMEOUT keeps it from wrapping.
   localparam logic [PER_W-1:0] WAIT_LAST = PER_W'(TRIG_CYCLES + ECHO_TIMEOUT - 1);
   localparam width_t           TIMEOUT_W = width_t'(ECHO_TIMEOUT);
   localparam width_t           NEAR_W    = width_t'(NEAR_THRESH);
   localparam logic [CONFIRM_W-1:0] CONFIRM_N = CONFIRM_W'(CONFIRM_COUNT);

   state_t               state_q;
   logic [PER_W-1:0]     period_q;
   width_t               width_q;
   logic [CONFIRM_W-1:0] confirm_q;
   logic                 start_q;
   logic                 trig_q;
   logic                 presence_q;
   width_t               echo_cycles_q;
   logic                 sample_valid_q;

   logic   echo_rise, echo_fall, echo_level;
   width_t width_inc_d;
   logic   rec_d;
   width_t rec_width_d;
   logic   near_d;

   echo_conditioner u_echo (
      .clk     (clk),
      .rst_n   (rst_n),
      .echo_i  (echo),
      .rise_o  (echo_rise),
      .fall_o  (echo_fall),
      .level_o (echo_level)
   );

   // Sample recording: a WAIT_RISE timeout, a falling edge, or the width
   // counter reaching the timeout inside MEASURE.
   always_comb begin
      width_inc_d = width_q;
      if (echo_level && (width_q != TIMEOUT_W)) begin
         width_inc_d = width_q + 21'd1;
      end

      rec_d       = 1'b0;
      rec_width_d = width_q;
      case (state_q)
         WAIT_RISE: begin
            if (!echo_rise && (period_q == WAIT_LAST)) begin
               rec_d       = 1'b1;
               rec_width_d = TIMEOUT_W;
            end
         end
         MEASURE: begin
            if (echo_fall || (width_inc_d == TIMEOUT_W)) begin
               rec_d       = 1'b1;
               rec_width_d = width_inc_d;
            end
         end
         default: ;
      endcase

      near_d = (rec_width_d < NEAR_W) && (rec_width_d != TIMEOUT_W);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         period_q       <= '0;
         width_q        <= '0;
         confirm_q      <= '0;
         start_q        <= 1'b1;
         trig_q         <= 1'b0;
         presence_q     <= 1'b0;
         echo_cycles_q  <= '0;
         sample_valid_q <= 1'b0;
      end else begin
         sample_valid_q <= rec_d;

         if (rec_d) begin
            echo_cycles_q <= rec_width_d;
            if (near_d != presence_q) begin
               if ((confirm_q + 4'd1) == CONFIRM_N) begin
                  presence_q <= ~presence_q;
                  confirm_q  <= '0;
               end else begin
                  confirm_q <= confirm_q + 4'd1;
               end
            end else begin
               confirm_q <= '0;
            end
         end

         period_q <= (period_q == PER_LAST) ? '0 : period_q + 1'b1;

         case (state_q)
            IDLE: begin
               if (start_q || (period_q == PER_LAST)) begin
                  state_q  <= TRIG;
                  trig_q   <= 1'b1;
                  start_q  <= 1'b0;
                  period_q <= '0;
               end
            end
            TRIG: begin
               if (period_q == TRIG_LAST) begin
                  state_q <= WAIT_RISE;
                  trig_q  <= 1'b0;
               end
            end
            WAIT_RISE: begin
               if (echo_rise) begin
                  width_q <= '0;
                  state_q <= MEASURE;
               end else if (rec_d) begin
                  state_q <= IDLE;
               end
            end
            MEASURE: begin
               if (rec_d) begin
                  state_q <= IDLE;
               end else begin
                  width_q <= width_inc_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign trig              = trig_q;
   assign presence_detected = presence_q;
   assign echo_cycles       = echo_cycles_q;
   assign sample_valid      = sample_valid_q;

endmodule

// File: tb/tb_presence_ultrasonic.sv
// tb/tb_presence_ultrasonic.sv - scoreboard bench for presence_ultrasonic

module tb_presence_ultrasonic;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        echo;
   logic        trig;
   logic        presence_detected;
   logic [20:0] echo_cycles;
   logic        sample_valid;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [20:0] cyc;
      logic        pres;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   presence_ultrasonic #(
      .TRIG_CYCLES   (10),
      .MEAS_PERIOD   (2000),
      .ECHO_TIMEOUT  (800),
      .NEAR_THRESH   (300),
      .CONFIRM_COUNT (3)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .echo              (echo),
      .trig              (trig),
      .presence_detected (presence_detected),
      .echo_cycles       (echo_cycles),
      .sample_valid      (sample_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic push_exp(input int cyc, input logic pres);
      exp_t e;
      e.cyc  = 21'(cyc);
      e.pres = pres;
      exp_q.push_back(e);
   endtask

   // Returns at the first negedge on which trig is low after a trig pulse.
   task automatic wait_trig_fall(output bit ok);
      int n = 0;
      while (trig !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      while (trig === 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      ok = (n < 4000);
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL trig_wait: no trigger pulse within %0d cycles", n);
      end
   endtask

   // width > 0: pulse of that many cycles; width < 0: raise and leave high;
   // width == 0: no echo driven, and the timeout sample time is checked.
   task automatic do_period(input int delay, input int width, input int exp_cyc, input logic exp_pres);
      bit ok;
      push_exp(exp_cyc, exp_pres);
      wait_trig_fall(ok);
      if (!ok) return;
      if (width == 0) begin
         repeat (799) @(negedge clk);
         check("timeout_not_early", sample_valid, 1'b0);
         @(negedge clk);
         check("timeout_at_800", sample_valid, 1'b1);
      end else begin
         repeat (delay) @(negedge clk);
         echo = 1'b1;
         if (width > 0) begin
            repeat (width) @(negedge clk);
            echo = 1'b0;
         end
      end
   endtask

   // Monitor: pops one expectation per sample_valid strobe.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sample_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_sample: echo_cycles=%0d, expected no sample", echo_cycles);
            end else begin
               e = exp_q.pop_front();
               check("echo_cycles", echo_cycles, e.cyc);
               check("presence", presence_detected, e.pres);
            end
         end
      end
   end

   initial begin : stimulus
      int hi;
      int total;
      bit ok;
      int n;

      rst_n = 1'b0;
      echo  = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_trig", trig, 1'b0);
      check("rst_presence", presence_detected, 1'b0);
      check("rst_echo_cycles", echo_cycles, 21'd0);
      check("rst_sample_valid", sample_valid, 1'b0);

      rst_n = 1'b1;
      @(negedge clk);
      check("trig_after_release", trig, 1'b1);

      // First period: no echo, timeout sample
      push_exp(800, 1'b0);
      hi = 0;
      while (trig === 1'b1 && hi < 100) begin
         hi++;
         @(negedge clk);
      end
      total = hi;
      while (trig !== 1'b1 && total < 4000) begin
         total++;
         @(negedge clk);
      end
      check("trig_width", hi, 10);
      check("trig_period", total, 2000);

      // Presence rises on the third consecutive near sample
      do_period(50, 200, 200, 1'b0);
      do_period(50, 200, 200, 1'b0);
      do_period(50, 200, 200, 1'b1);
      // Two far, one near: confirm counter cleared, presence held
      do_period(50, 500, 500, 1'b1);
      do_period(50, 500, 500, 1'b1);
      do_period(50, 200, 200, 1'b1);
      // Three far: presence drops
      do_period(50, 500, 500, 1'b1);
      do_period(50, 500, 500, 1'b1);
      do_period(50, 500, 500, 1'b0);
      // Threshold boundary: 300 is far, 299 is near; timeout is far
      do_period(50, 300, 300, 1'b0);
      do_period(50, 299, 299, 1'b0);
      do_period(50, 299, 299, 1'b0);
      do_period(0, 0, 800, 1'b0);
      do_period(50, 299, 299, 1'b0);
      do_period(50, 299, 299, 1'b0);
      do_period(50, 299, 299, 1'b1);

      // Reset pulse in the middle of a measurement
      wait_trig_fall(ok);
      repeat (50) @(negedge clk);
      echo = 1'b1;
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_trig", trig, 1'b0);
      check("midrst_presence", presence_detected, 1'b0);
      check("midrst_echo_cycles", echo_cycles, 21'd0);
      check("midrst_sample_valid", sample_valid, 1'b0);
      rst_n = 1'b1;
      echo  = 1'b0;
      @(negedge clk);
      check("trig_after_midrst", trig, 1'b1);
      do_period(0, 0, 800, 1'b0);

      // Saturation: long pulse, then stuck-high echo and its follow-up timeout
      do_period(50, 1500, 800, 1'b0);
      do_period(50, -1, 800, 1'b0);
      do_period(0, 0, 800, 1'b0);
      repeat (100) @(negedge clk);
      echo = 1'b0;

      // Two-cycle glitch
`ifdef ECHO_DEGLITCH_EN
      do_period(50, 2, 800, 1'b0);
`else
      do_period(50, 2, 2, 1'b0);
`endif

      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("pending_samples", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/presence_ultrasonic.md
Name: presence_ultrasonic

Overview:
Drives an HC-SR04-style ultrasonic ranger and measures the echo pulse width in clock cycles. It turns the distance into a debounced presence flag for the door servo stage directly downstream. That stage opens the door while presence_detected is low and closes it after 2.5 s of continuous presence. This block therefore guarantees that presence_detected is glitch-free and changes only after consecutive agreeing measurements.

Parameters:
TRIG_CYCLES, 500, trigger pulse width (10 us @ 50 MHz)
MEAS_PERIOD, 3_000_000, cycles between trigger rising edges (60 ms)
ECHO_TIMEOUT, 1_250_000, maximum wait for echo rise, and maximum echo width (25 ms); constraint TRIG_CYCLES + 2*ECHO_TIMEOUT < MEAS_PERIOD
NEAR_THRESH, 58_000, echo widths strictly below this count as "near" (about 20 cm)
CONFIRM_COUNT, 3, consecutive agreeing samples needed to change presence_detected (range 1..15)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  synchronous reset, active low
echo  input  1  asynchronous echo from the sensor
trig  output  1  trigger pulse to the sensor
presence_detected  output  1  debounced presence, active high
echo_cycles  output  21  last measured echo width in clk cycles, saturated at ECHO_TIMEOUT
sample_valid  output  1  one-cycle strobe; echo_cycles was updated this cycle

Behaviour:
- Reset is synchronous and active-low on clk. While rst_n=0:
  - trig=0, presence_detected=0, echo_cycles=0, sample_valid=0.
  - FSM is in IDLE; period counter, width counter and confirm counter are all 0.
- Reset asserted mid-operation aborts everything at the next edge, including dropping trig.
- echo passes through a 2-FF synchronizer, then a registered edge detector. Both echo edges are seen 3 cycles late, so measured width is unaffected.
- Period counter:
  - Free-running; wraps MEAS_PERIOD-1 -> 0.
  - Resets to 0 on the cycle the FSM leaves IDLE.
- FSM states and transitions:
  - IDLE: after reset release, go to TRIG on the next cycle. Otherwise go to TRIG when the period counter wraps to 0.
  - TRIG: trig=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE.
  - WAIT_RISE: wait for a synchronized rising edge. A level already high on entry is stale and is not a rise.
    - Rising edge: clear the width counter, go to MEASURE.
    - ECHO_TIMEOUT cycles in this state with no edge: record a "timeout" sample, go to IDLE.
  - MEASURE: the width counter increments each cycle the synchronized echo is high.
    - Falling edge: record a sample of the counter value, go to IDLE.
    - Counter reaches ECHO_TIMEOUT: record a saturated sample (ECHO_TIMEOUT), go to IDLE. The rest of that echo pulse is ignored.
- Recording a sample (all registered, visible together one edge later):
  - sample_valid pulses 1 cycle.
  - echo_cycles is loaded with the width; a timeout sample loads ECHO_TIMEOUT.
  - Classification: near iff width < NEAR_THRESH. A timeout or saturated sample is far. Width equal to NEAR_THRESH is far.
- Debounce:
  - A sample that disagrees with the current presence_detected increments the confirm counter. An agreeing sample clears it.
  - When the counter reaches CONFIRM_COUNT, presence_detected toggles and the counter clears.
  - With CONFIRM_COUNT=1, presence_detected follows each sample directly.
- presence_detected changes only in the sample_valid cycle. It never changes during TRIG, WAIT_RISE or MEASURE.
- Width arithmetic is unsigned and saturating; there is no wrap of the width counter.

Optional Feature:
ECHO_DEGLITCH_EN
- Defined: the synchronized echo feeds a 4-cycle stability filter. The filtered output changes only after 4 consecutive equal input samples. Pulses shorter than 4 cycles are rejected. Both edges gain 4 cycles of latency, so width is unchanged for clean pulses.
- Undefined: the synchronizer output feeds the edge detector directly.

Decomposition:
- Package presence_pkg holds:
  - the FSM state enum (IDLE, TRIG, WAIT_RISE, MEASURE);
  - the 21-bit width typedef;
  - default timing constants, shared with the servo stage's 50 MHz figures.
- Sub-module echo_conditioner holds the 2-FF synchronizer, the optional deglitch filter and the rise/fall strobes.
- The FSM, counters and debounce stay in the top module.

Test Plan (sim overrides: TRIG_CYCLES=10, MEAS_PERIOD=2000, ECHO_TIMEOUT=800, NEAR_THRESH=300, CONFIRM_COUNT=3):
- Reset release -> trig high 10 cycles starting one cycle after release; next trig rises exactly 2000 cycles later; all outputs 0 before release.
- Echo high 200 cycles, 50 cycles after trig falls -> sample_valid once, echo_cycles=200. presence_detected rises only on the 3rd consecutive such sample.
- Presence set, then echo 500 cycles for two periods, then 200 cycles -> presence stays 1 (confirm counter cleared). Three 500-cycle echoes -> presence 0.
- No echo at all -> timeout sample 800 cycles after trig falls, echo_cycles=800, classified far.
- Echo stuck high, or held 1500 cycles -> echo_cycles=800 saturated. A stuck-high echo produces no rise in the next period, so timeout again.
- rst_n low for 1 cycle during MEASURE -> trig/presence/echo_cycles 0 next edge, no sample_valid, fresh trigger after release. With ECHO_DEGLITCH_EN, a 2-cycle glitch on echo -> no sample recorded from it.
